// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter between the I-cache and
// D-cache miss/write-back interfaces.
//   arb_state_e  : arbiter FSM state encoding
//   GNT_*        : encodings of the 2-bit grant status output
//   *_W_DEF      : default address / data widths
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single off-chip memory port between the I-cache and D-cache.
// One requester is granted at a time; the grant is held until mem_ready,
// and contention alternates between the two caches so neither starves.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_mem_read/addr                I-cache line-fill request (held until ready)
//   i_mem_rdata/ready              fill data / completion strobe to I-cache
//   d_mem_read/write/addr/wdata    D-cache fill / write-back request
//   d_mem_rdata/ready              fill data / completion strobe to D-cache
//   mem_read/write/addr/wdata      registered memory request
//   mem_rdata/ready                memory read data / single-cycle completion
//   grant                          00 none, 01 I, 10 D
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; arbitrate pending requests
// SERVE_I | I-cache access on the memory port, waiting for mem_ready
// SERVE_D | D-cache access on the memory port, waiting for mem_ready
// RELEASE | one dead cycle; requests ignored so a stale request is dropped
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  arb_state_e state_q, state_d;
  // 1 when the D-cache was served most recently; resets to I so D wins
  // the first contention.
  logic last_d_q, last_d_d;
  logic load_i, load_d, clear_req;
  logic i_req, d_req;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    load_i    = 1'b0;
    load_d    = 1'b0;
    clear_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_d_q) load_i = 1'b1;
          else          load_d = 1'b1;
        end else if (i_req) begin
          load_i = 1'b1;
        end else if (d_req) begin
          load_d = 1'b1;
        end
        if (load_i) state_d = SERVE_I;
        if (load_d) state_d = SERVE_D;
      end
      SERVE_I: begin
        if (mem_ready) begin
          state_d   = RELEASE;
          last_d_d  = 1'b0;
          clear_req = 1'b1;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          state_d   = RELEASE;
          last_d_d  = 1'b1;
          clear_req = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Memory request registers: loaded only on the grant edge and held for
  // the whole access, so requester inputs never reach mem_* directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load_i) begin
      mem_read  <= 1'b1;
      mem_write <= 1'b0;
      mem_addr  <= i_mem_addr;
      mem_wdata <= '0;
    end else if (load_d) begin
      // A simultaneous read and write-back from the D-cache issues the write.
      mem_read  <= d_mem_read & ~d_mem_write;
      mem_write <= d_mem_write;
      mem_addr  <= d_mem_addr;
      mem_wdata <= d_mem_wdata;
    end else if (clear_req) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  assign i_mem_ready = mem_ready & (state_q == SERVE_I);
  assign d_mem_ready = mem_ready & (state_q == SERVE_D);
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  always_comb begin
    grant = GNT_NONE;
    case (state_q)
      SERVE_I: grant = GNT_I;
      SERVE_D: grant = GNT_D;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized request traffic, checked against a transaction-level model of
// pending requests, the alternating-priority rule and the fixed handoff
// timing around each memory completion.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_read  (i_mem_read),
    .i_mem_addr  (i_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata),
    .d_mem_ready (d_mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .grant       (grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: which caches have an outstanding request and who was
  // served last.
  bit            pi, pd, pd_rd, pd_wr;
  logic [AW-1:0] pi_addr, pd_addr;
  logic [DW-1:0] pd_wdata;
  bit            last_d;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    i_mem_read  = pi;
    i_mem_addr  = pi_addr;
    d_mem_read  = pd & pd_rd;
    d_mem_write = pd & pd_wr;
    d_mem_addr  = pd_addr;
    d_mem_wdata = pd_wdata;
  endtask

  task automatic new_i(input logic [AW-1:0] a);
    pi = 1'b1; pi_addr = a;
    i_mem_read = 1'b1; i_mem_addr = a;
  endtask

  task automatic new_d(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    pd = 1'b1; pd_rd = rd; pd_wr = wr; pd_addr = a; pd_wdata = wd;
    d_mem_read = rd; d_mem_write = wr; d_mem_addr = a; d_mem_wdata = wd;
  endtask

  task automatic new_d_rand();
    int k;
    k = $urandom_range(0, 2);
    new_d(k != 1, k != 0, AW'($urandom),
          {$urandom, $urandom, $urandom, $urandom});
  endtask

  // Called in an IDLE cycle with the pending requests already driven.
  // Returns two cycles after the completion cycle (the first cycle in which
  // a new request can be seen by the arbiter).
  task automatic run_txn(input int lat, input logic [DW-1:0] rdat,
                         input bit stale, input bit ready_idle);
    bit            win_d, e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_gnt;
    win_d = (pi && pd) ? !last_d : pd;
    if (win_d) begin
      e_addr = pd_addr; e_wdata = pd_wdata;
      e_wr = pd_wr; e_rd = pd_rd && !pd_wr; e_gnt = GNT_D;
    end else begin
      e_addr = pi_addr; e_wdata = '0;
      e_wr = 1'b0; e_rd = 1'b1; e_gnt = GNT_I;
    end
    drive_reqs();
    cyc();
    mem_ready = 1'b0;
    check_val("grant_start", 128'(grant), 128'(e_gnt));
    check_val("mem_read_start", 128'(mem_read), 128'(e_rd));
    check_val("mem_write_start", 128'(mem_write), 128'(e_wr));
    check_val("mem_addr_start", 128'(mem_addr), 128'(e_addr));
    check_val("mem_wdata_start", mem_wdata, e_wdata);
    for (int c = 1; c < lat; c++) begin
      // The granted cache wiggles its inputs; the arbiter must ignore them.
      if (win_d) begin
        d_mem_addr  = AW'($urandom);
        d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
        if (!pi && $urandom_range(0, 2) == 0) new_i(AW'($urandom));
      end else begin
        i_mem_addr = AW'($urandom);
        if ($urandom_range(0, 3) == 0) i_mem_read = 1'b0;
        if (!pd && $urandom_range(0, 2) == 0) new_d_rand();
      end
      cyc();
      check_val("mem_addr_hold", 128'(mem_addr), 128'(e_addr));
      check_val("mem_rw_hold", 128'({mem_read, mem_write}), 128'({e_rd, e_wr}));
      check_val("grant_hold", 128'(grant), 128'(e_gnt));
      check_val("ready_early", 128'({i_mem_ready, d_mem_ready}), 128'(0));
    end
    mem_rdata = rdat;
    mem_ready = 1'b1;
    #1;
    check_val("i_ready", 128'(i_mem_ready), 128'(!win_d));
    check_val("d_ready", 128'(d_mem_ready), 128'(win_d));
    check_val("i_rdata", i_mem_rdata, rdat);
    check_val("d_rdata", d_mem_rdata, rdat);
    cyc();
    // Cycle after completion: memory request dropped, arbiter in RELEASE.
    if (win_d) pd = 1'b0; else pi = 1'b0;
    last_d = win_d;
    mem_ready = ready_idle;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    drive_reqs();
    if (stale) begin
      if (win_d) begin d_mem_read = 1'b1; d_mem_write = e_wr; end
      else i_mem_read = 1'b1;
    end
    #1;
    check_val("rel_rw", 128'({mem_read, mem_write}), 128'(0));
    check_val("rel_grant", 128'(grant), 128'(GNT_NONE));
    check_val("rel_ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
    cyc();
    drive_reqs();
    mem_ready = ready_idle;
    #1;
    check_val("idle_rw", 128'({mem_read, mem_write}), 128'(0));
    check_val("idle_grant", 128'(grant), 128'(GNT_NONE));
    check_val("idle_ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pi = 0; pd = 0; pd_rd = 0; pd_wr = 0; last_d = 0;
    pi_addr = '0; pd_addr = '0; pd_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    drive_reqs();
    #3;
    check_val("rst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
    check_val("rst_mem_addr", 128'(mem_addr), 128'(0));
    check_val("rst_mem_wdata", mem_wdata, 128'(0));
    check_val("rst_ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
    check_val("rst_grant", 128'(grant), 128'(GNT_NONE));
    #9 rst_n = 1'b1;
    cyc();

    // Contention right after reset: D first, then I three cycles after ready.
    new_i(28'h0000100);
    new_d(1'b1, 1'b0, 28'h0000300, 128'h0);
    run_txn(3, {4{32'hC0FFEE01}}, 1'b0, 1'b0);
    run_txn(2, {4{32'h0BADF00D}}, 1'b0, 1'b0);

    // Both caches request continuously: D, I, D, I.
    for (int t = 0; t < 4; t++) begin
      if (!pi) new_i(AW'($urandom));
      if (!pd) new_d_rand();
      run_txn($urandom_range(1, 4), {$urandom, $urandom, $urandom, $urandom},
              1'b0, 1'b0);
      check_val("alt_order", 128'(last_d), 128'((t % 2) == 0));
    end
    pi = 0; pd = 0; drive_reqs();
    cyc();

    // Single I read.
    new_i(28'h0000010);
    run_txn(4, {16{8'hA5}}, 1'b0, 1'b0);

    // D write-back.
    new_d(1'b0, 1'b1, 28'h0000200, 128'h123456789ABCDEF00FEDCBA987654321);
    run_txn(3, {4{32'h55AA55AA}}, 1'b0, 1'b0);

    // Stale request held past ready, with mem_ready pulsing while idle.
    new_i(28'h0000440);
    run_txn(2, {4{32'h13579BDF}}, 1'b1, 1'b1);
    cyc();
    mem_ready = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!pi && !pd) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          mem_ready = 1'($urandom_range(0, 1));
          #1;
          check_val("gap_ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
          check_val("gap_grant", 128'(grant), 128'(GNT_NONE));
          cyc();
        end
        case ($urandom_range(1, 3))
          1: new_i(AW'($urandom));
          2: new_d_rand();
          default: begin new_i(AW'($urandom)); new_d_rand(); end
        endcase
      end else if ($urandom_range(0, 1) == 1) begin
        if (!pi) new_i(AW'($urandom));
        if (!pd) new_d_rand();
      end
      run_txn($urandom_range(1, 6), {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    pi = 0; pd = 0; drive_reqs();
    mem_ready = 1'b0;
    cyc();
    cyc();

    // Asynchronous reset in the middle of a D write-back.
    new_d(1'b0, 1'b1, 28'h0ABCDEF, {4{32'hDEADBEEF}});
    cyc();
    check_val("pre_rst_grant", 128'(grant), 128'(GNT_D));
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
    check_val("arst_mem_addr", 128'(mem_addr), 128'(0));
    check_val("arst_mem_wdata", mem_wdata, 128'(0));
    check_val("arst_grant", 128'(grant), 128'(GNT_NONE));
    check_val("arst_ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
    pi = 0; pd = 0; last_d = 0;
    drive_reqs();
    #2 rst_n = 1'b1;
    cyc();
    new_i(28'h0000020);
    new_d(1'b1, 1'b0, 28'h0000040, 128'h0);
    run_txn(2, {4{32'h2468ACE0}}, 1'b0, 1'b0);
    run_txn(3, {4{32'h1F2E3D4C}}, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
